// File: rtl/frame_buffer_pkg.sv
// Shared definitions for the text-mode frame buffer and its console sequencer.
//   state_t       : console controller states
//   CHR_*         : control codes interpreted by the console
//   clog2         : ceiling log2 helper for sizing address buses
package frame_buffer_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FILL,
        ST_IDLE,
        ST_WRITE,
        ST_SCROLL_RD,
        ST_SCROLL_WR,
        ST_LFILL
    } state_t;

    localparam logic [7:0] CHR_BS = 8'h08;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_FF = 8'h0C;
    localparam logic [7:0] CHR_CR = 8'h0D;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// Byte-stream and display-RAM bus of the text console controller.
//   in_valid/in_data/in_ready : character byte handshake
//   clear                     : single-cycle clear-screen request
//   ram_addr/ram_wdata/ram_we : display RAM write/read address port
//   ram_rdata                 : synchronous read data (address of previous edge)
// Modports: slave = console controller, master = byte source plus RAM.
interface text_console_ctrl_if #(
    parameter int ADDR_W = 11
) ();

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              clear;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic [7:0]        ram_rdata;

    modport slave (
        input  in_valid, in_data, clear, ram_rdata,
        output in_ready, ram_addr, ram_wdata, ram_we
    );

    modport master (
        output in_valid, in_data, clear, ram_rdata,
        input  in_ready, ram_addr, ram_wdata, ram_we
    );

endinterface

// File: rtl/text_console_ctrl.sv
// Text console sequencer: turns a character byte stream into display RAM
// writes for an 80x25 text frame buffer, keeps a cursor, interprets
// CR/LF/BS/FF, and performs screen clear and one-line hardware scroll by
// reading and rewriting the display RAM.
//   clock, reset_n         : clock, synchronous active-low reset
//   bus (slave modport)    : byte handshake, clear request, display RAM port
//   cursor_col, cursor_row : current cursor position
//   busy                   : high whenever the sequencer is not idle
module text_console_ctrl
    import frame_buffer_pkg::*;
#(
    parameter int         DISP_W    = 80,
    parameter int         DISP_H    = 25,
    parameter int         ADDR_W    = 11,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic                clock,
    input  logic                reset_n,
    text_console_ctrl_if.slave  bus,
    output logic [6:0]          cursor_col,
    output logic [4:0]          cursor_row,
    output logic                busy
);

    localparam logic [ADDR_W-1:0] W_A           = ADDR_W'(DISP_W);
    localparam logic [ADDR_W-1:0] LAST_CELL     = ADDR_W'(DISP_W * DISP_H - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((DISP_H - 1) * DISP_W);
    localparam logic [6:0]        LAST_COL      = 7'(DISP_W - 1);
    localparam logic [4:0]        LAST_ROW      = 5'(DISP_H - 1);

    state_t            state;
    logic [6:0]        col;
    logic [4:0]        row;
    logic              clear_pend;
    // Shared sweep counter: fill address, scroll source, or line-fill address.
    logic [ADDR_W-1:0] cnt;
    logic [7:0]        wbyte;
    logic              printable;
    logic [ADDR_W-1:0] cell_addr;

    assign printable  = (bus.in_data >= 8'h20) && (bus.in_data != 8'h7F);
    assign cell_addr  = ADDR_W'(row) * W_A + ADDR_W'(col);
    assign bus.in_ready = (state == ST_IDLE) && !bus.clear && !clear_pend;
    assign busy       = (state != ST_IDLE);
    assign cursor_col = col;
    assign cursor_row = row;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_INIT;
            col        <= '0;
            row        <= '0;
            clear_pend <= 1'b0;
            cnt        <= '0;
        end else begin
            // A clear arriving while busy is remembered; repeats collapse.
            if (state != ST_IDLE && bus.clear) begin
                clear_pend <= 1'b1;
            end
            case (state)
                ST_INIT: begin
                    state <= ST_FILL;
                    cnt   <= '0;
                end
                ST_FILL: begin
                    if (cnt == LAST_CELL) begin
                        state <= ST_IDLE;
                        col   <= '0;
                        row   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.clear || clear_pend) begin
                        state      <= ST_FILL;
                        cnt        <= '0;
                        clear_pend <= 1'b0;
                    end else if (bus.in_valid) begin
                        if (printable) begin
                            state <= ST_WRITE;
                        end else begin
                            case (bus.in_data)
                                CHR_CR: col <= '0;
                                CHR_LF: begin
                                    col <= '0;
                                    if (row < LAST_ROW) begin
                                        row <= row + 1'b1;
                                    end else begin
                                        state <= ST_SCROLL_RD;
                                        cnt   <= W_A;
                                    end
                                end
                                CHR_BS: begin
                                    if (col != '0) col <= col - 1'b1;
                                end
                                CHR_FF: begin
                                    state <= ST_FILL;
                                    cnt   <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_WRITE: begin
                    if (col < LAST_COL) begin
                        col   <= col + 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        col <= '0;
                        if (row < LAST_ROW) begin
                            row   <= row + 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_SCROLL_RD;
                            cnt   <= W_A;
                        end
                    end
                end
                ST_SCROLL_RD: state <= ST_SCROLL_WR;
                ST_SCROLL_WR: begin
                    if (cnt == LAST_CELL) begin
                        state <= ST_LFILL;
                        cnt   <= LAST_ROW_BASE;
                    end else begin
                        state <= ST_SCROLL_RD;
                        cnt   <= cnt + 1'b1;
                    end
                end
                ST_LFILL: begin
                    if (cnt == LAST_CELL) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Character latch: the byte captured on the accepting edge is the one
    // written in ST_WRITE.
    always_ff @(posedge clock) begin
        if (state == ST_IDLE) begin
            wbyte <= bus.in_data;
        end
    end

    // RAM port decode; ram_rdata passes straight through only while
    // rewriting a scrolled cell one row up.
    always_comb begin
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        case (state)
            ST_FILL, ST_LFILL: begin
                bus.ram_we    = 1'b1;
                bus.ram_addr  = cnt;
                bus.ram_wdata = FILL_CHAR;
            end
            ST_WRITE: begin
                bus.ram_we    = 1'b1;
                bus.ram_addr  = cell_addr;
                bus.ram_wdata = wbyte;
            end
            ST_SCROLL_RD: begin
                bus.ram_addr  = cnt;
            end
            ST_SCROLL_WR: begin
                bus.ram_we    = 1'b1;
                bus.ram_addr  = cnt - W_A;
                bus.ram_wdata = bus.ram_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Testbench for text_console_ctrl: display RAM model, screen-level
// reference model, directed steps plus randomized byte streams.
module tb_text_console_ctrl;
    import frame_buffer_pkg::*;

    localparam int DISP_W = 80;
    localparam int DISP_H = 25;
    localparam int ADDR_W = 11;
    localparam int CELLS  = DISP_W * DISP_H;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] scr [0:CELLS-1];
    int         rc, rr;

    text_console_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    text_console_ctrl #(
        .DISP_W(DISP_W), .DISP_H(DISP_H), .ADDR_W(ADDR_W), .FILL_CHAR(8'h20)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus.slave),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Synchronous-read display RAM
    always @(posedge clock) begin
        bus.ram_rdata <= mem[bus.ram_addr];
        if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_wdata;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- screen-level reference model ----------------
    function automatic void ref_clear();
        for (int i = 0; i < CELLS; i++) scr[i] = 8'h20;
        rc = 0;
        rr = 0;
    endfunction

    function automatic void ref_newline();
        if (rr < DISP_H - 1) rr++;
        else begin
            for (int i = 0; i < CELLS - DISP_W; i++) scr[i] = scr[i + DISP_W];
            for (int i = CELLS - DISP_W; i < CELLS; i++) scr[i] = 8'h20;
        end
    endfunction

    function automatic void ref_apply(input logic [7:0] b);
        if (b == CHR_FF) ref_clear();
        else if (b == CHR_CR) rc = 0;
        else if (b == CHR_LF) begin rc = 0; ref_newline(); end
        else if (b == CHR_BS) begin if (rc > 0) rc--; end
        else if (b >= 8'h20 && b != 8'h7F) begin
            scr[rr * DISP_W + rc] = b;
            if (rc < DISP_W - 1) rc++;
            else begin rc = 0; ref_newline(); end
        end
    endfunction

    function automatic logic [7:0] rand_byte();
        int sel;
        sel = $urandom_range(0, 63);
        if (sel < 44)      return 8'($urandom_range(32, 126));
        else if (sel < 48) return 8'($urandom_range(128, 255));
        else if (sel < 51) return CHR_CR;
        else if (sel < 54) return CHR_LF;
        else if (sel < 57) return CHR_BS;
        else if (sel < 59) return 8'h7F;
        else if (sel < 63) return 8'($urandom_range(0, 31));
        else               return CHR_FF;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_screen(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (mem[i] !== scr[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clock);
        while (bus.in_ready !== 1'b1 && t < 20000) begin
            @(negedge clock);
            t++;
        end
        check("in_ready_wait", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        ref_apply(b);
    endtask

    // Counts busy cycles (sampled at negedges) until the controller idles.
    task automatic wait_idle(output int cyc, output int rdy);
        cyc = 0;
        rdy = 0;
        @(negedge clock);
        while (busy !== 1'b0 && cyc < 20000) begin
            if (bus.in_ready !== 1'b0) rdy++;
            cyc++;
            @(negedge clock);
        end
        check("idle_reached", busy, 0);
    endtask

    initial begin
        int cyc, rdy, bad;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.clear    = 1'b0;
        reset_n      = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clock);
        #1;
        check("rst_we", bus.ram_we, 0);
        check("rst_addr", bus.ram_addr, 0);
        check("rst_wdata", bus.ram_wdata, 0);
        check("rst_ready", bus.in_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_col", cursor_col, 0);
        check("rst_row", cursor_row, 0);

        // ---- reset release: full-screen fill 0..1999 ----
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        bad = 0;
        for (int i = 0; i < CELLS; i++) begin
            @(negedge clock);
            if (bus.ram_we !== 1'b1 || bus.ram_addr !== ADDR_W'(i) || bus.ram_wdata !== 8'h20) bad++;
        end
        check("init_fill_sequence", bad, 0);
        @(negedge clock);
        check("init_busy", busy, 0);
        check("init_ready", bus.in_ready, 1);
        check("init_col", cursor_col, 0);
        check("init_row", cursor_row, 0);
        ref_clear();
        cmp_screen("init_screen");

        // ---- 'A','B' back-to-back ----
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h41;
        check("ab_ready_a", bus.in_ready, 1);
        @(posedge clock);
        #1;
        bus.in_data = 8'h42;
        @(negedge clock);
        check("ab_ready_after_a", bus.in_ready, 0);
        @(negedge clock);
        check("ab_ready_b", bus.in_ready, 1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clock);
        check("ab_ready_after_b", bus.in_ready, 0);
        ref_apply(8'h41);
        ref_apply(8'h42);
        wait_idle(cyc, rdy);
        check("ab_mem0", mem[0], 8'h41);
        check("ab_mem1", mem[1], 8'h42);
        check("ab_col", cursor_col, 2);
        check("ab_row", cursor_row, 0);

        // ---- CR, LF, BS at column 0 ----
        send_byte(CHR_CR);
        send_byte(CHR_LF);
        wait_idle(cyc, rdy);
        check("crlf_col", cursor_col, 0);
        check("crlf_row", cursor_row, 1);
        send_byte(CHR_BS);
        wait_idle(cyc, rdy);
        check("bs0_col", cursor_col, 0);
        check("bs0_row", cursor_row, 1);
        send_byte(8'h58);
        send_byte(CHR_BS);
        wait_idle(cyc, rdy);
        check("xbs_mem80", mem[80], 8'h58);
        check("xbs_col", cursor_col, 0);
        check("xbs_row", cursor_row, 1);
        cmp_screen("crlfbs_screen");

        // ---- form feed, then 2000 printable bytes ending in a scroll ----
        send_byte(CHR_FF);
        wait_idle(cyc, rdy);
        check("ff_fill_cycles", cyc, CELLS);
        check("ff_col", cursor_col, 0);
        check("ff_row", cursor_row, 0);
        for (int i = 0; i < CELLS - 1; i++) send_byte(8'((i % 95) + 32));
        send_byte(8'(((CELLS - 1) % 95) + 32));
        wait_idle(cyc, rdy);
        // WRITE of the last byte, 1920 read/write pairs, 80-cell line fill
        check("scroll_busy_cycles", cyc, 1 + 3840 + 80);
        check("scroll_mem0", mem[0], 8'h70);
        check("scroll_mem1919", mem[1919], 8'h24);
        check("scroll_mem1920", mem[1920], 8'h20);
        check("scroll_mem1999", mem[1999], 8'h20);
        check("scroll_col", cursor_col, 0);
        check("scroll_row", cursor_row, 24);
        cmp_screen("scroll_screen");

        // ---- clear pulsed twice during a scroll: one fill afterwards ----
        send_byte(CHR_LF);
        cyc = 0;
        rdy = 0;
        @(negedge clock);
        while (busy !== 1'b0 && cyc < 20000) begin
            if (bus.in_ready !== 1'b0) rdy++;
            bus.clear = (cyc == 1000 || cyc == 2501);
            cyc++;
            @(negedge clock);
        end
        bus.clear = 1'b0;
        check("clr_scroll_cycles", cyc, 3840 + 80);
        check("clr_ready_pending", bus.in_ready, 0);
        check("clr_ready_scroll", rdy, 0);
        wait_idle(cyc, rdy);
        check("clr_fill_cycles", cyc, CELLS);
        check("clr_ready_fill", rdy, 0);
        check("clr_col", cursor_col, 0);
        check("clr_row", cursor_row, 0);
        ref_clear();
        cmp_screen("clr_screen");
        @(negedge clock);
        check("clr_no_second_fill", busy, 0);

        // ---- randomized byte streams ----
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 100; j++) begin
                send_byte(rand_byte());
                repeat ($urandom_range(0, 2)) @(negedge clock);
            end
            wait_idle(cyc, rdy);
            check("rand_col", cursor_col, 7'(rc));
            check("rand_row", cursor_row, 5'(rr));
            cmp_screen("rand_screen");
        end

        // ---- reset in the middle of a fill ----
        send_byte(8'h51);
        send_byte(8'h5A);
        send_byte(CHR_FF);
        cyc = 0;
        @(negedge clock);
        while (bus.ram_addr !== 11'd500 && cyc < 3000) begin
            cyc++;
            @(negedge clock);
        end
        check("mid_fill_addr500", bus.ram_addr, 500);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("mid_rst_we", bus.ram_we, 0);
        check("mid_rst_addr", bus.ram_addr, 0);
        check("mid_rst_busy", busy, 1);
        check("mid_rst_ready", bus.in_ready, 0);
        check("mid_rst_col", cursor_col, 0);
        check("mid_rst_row", cursor_row, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("mid_restart_we", bus.ram_we, 1);
        check("mid_restart_addr", bus.ram_addr, 0);
        check("mid_restart_wdata", bus.ram_wdata, 8'h20);
        wait_idle(cyc, rdy);
        check("mid_restart_cycles", cyc, CELLS);
        ref_clear();
        cmp_screen("mid_restart_screen");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
